// File: rtl/video_raster_irq_if.sv
// video_raster_irq_if: CPU-side IO register window of the raster IRQ block.
//   io_addr    register select (5 bits)
//   io_wrdata  register write data
//   io_wren    write strobe, one cycle per write
//   io_rddata  register read data (combinational in the slave)
interface video_raster_irq_if;
  logic [4:0] io_addr;
  logic [7:0] io_wrdata;
  logic       io_wren;
  logic [7:0] io_rddata;

  modport master (output io_addr, io_wrdata, io_wren, input io_rddata);
  modport slave  (input io_addr, io_wrdata, io_wren, output io_rddata);
endinterface

// File: rtl/video_raster_irq.sv
// video_raster_irq: NUM_CH raster-line compare channels plus a vblank source,
// each with a mask bit and a sticky status bit, combined into one registered
// CPU interrupt line. Each channel can auto-step its compare line after every
// hit (wrapping at VTOTAL) so one channel can raise several split-screen
// interrupts per frame; vblank re-arms every channel from its BASE.
//   clk, reset_n  clock, asynchronous active-low reset
//   io            register window (slave): addr/wrdata/wren in, rddata out
//   vpos          current line from video_timing
//   vblank        vertical blank level from video_timing
//   irq           registered interrupt request, active high
module video_raster_irq #(
  parameter int NUM_CH = 4,
  parameter int VPOS_W = 9,
  parameter int VTOTAL = 262
) (
  input  logic                clk,
  input  logic                reset_n,
  video_raster_irq_if.slave   io,
  input  logic [VPOS_W-1:0]   vpos,
  input  logic                vblank,
  output logic                irq
);

  localparam logic [6:0]      CH_BITS = 7'((1 << NUM_CH) - 1);
  localparam logic [7:0]      VALID   = {1'b1, CH_BITS};
  localparam logic [VPOS_W:0] VTOT    = (VPOS_W + 1)'(VTOTAL);

  // Next compare line after a hit, wrapped into 0..VTOTAL-1.
  function automatic logic [VPOS_W-1:0] step_wrap(input logic [VPOS_W-1:0] cur,
                                                  input logic [7:0] step);
    logic [VPOS_W:0] sum;
    sum = {1'b0, cur} + (VPOS_W + 1)'(step);
    if (sum >= VTOT) sum = sum - VTOT;
    return sum[VPOS_W-1:0];
  endfunction

  logic [VPOS_W-1:0] base_q  [NUM_CH];
  logic [VPOS_W-1:0] base_nx [NUM_CH];
  logic [VPOS_W-1:0] cur_q   [NUM_CH];
  logic [7:0]        step_q  [NUM_CH];
  logic [NUM_CH-1:0] match_p0, match_p1, hit_p0, base_wr, step_wr;
  logic [7:0]        mask_q, stat_q, stat_set, stat_clr, rdata;
  logic              vblank_p1, vblank_rise, wr_mask, wr_stat;

  // Stage p0: register decode, line compare, edge detect
  always_comb begin
    wr_mask     = io.io_wren && (io.io_addr == 5'd0);
    wr_stat     = io.io_wren && (io.io_addr == 5'd1);
    vblank_rise = vblank && !vblank_p1;
    for (int i = 0; i < NUM_CH; i++) begin
      base_nx[i] = base_q[i];
      base_wr[i] = 1'b0;
      step_wr[i] = 1'b0;
      if (io.io_wren && (io.io_addr[4:2] == 3'(i + 2))) begin
        case (io.io_addr[1:0])
          2'd0: begin
            base_nx[i][7:0] = io.io_wrdata;
            base_wr[i]      = 1'b1;
          end
          // High byte: bits above VPOS_W fall off in the truncating cast.
          2'd1: begin
            base_nx[i] = VPOS_W'({io.io_wrdata, base_q[i][7:0]});
            base_wr[i] = 1'b1;
          end
          2'd2:    step_wr[i] = 1'b1;
          default: ;
        endcase
      end
      match_p0[i] = (vpos == cur_q[i]);
      hit_p0[i]   = match_p0[i] && !match_p1[i];
    end
    // Hardware set is OR-ed in after the clear so it wins on the same bit.
    stat_set = {vblank_rise, 7'(hit_p0)};
    stat_clr = wr_stat ? io.io_wrdata : 8'h00;
  end

  // Stage p1: state update; irq follows STAT/MASK one clock later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= 8'h00;
      stat_q    <= 8'h00;
      irq       <= 1'b0;
      vblank_p1 <= 1'b0;
      match_p1  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= '0;
        cur_q[i]  <= '0;
        step_q[i] <= 8'h00;
      end
    end else begin
      vblank_p1 <= vblank;
      match_p1  <= match_p0;
      if (wr_mask) mask_q <= io.io_wrdata & VALID;
      stat_q <= ((stat_q & ~stat_clr) | stat_set) & VALID;
      irq    <= |(stat_q & mask_q);
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= base_nx[i];
        if (step_wr[i]) step_q[i] <= io.io_wrdata;
        // CPU base write and vblank re-arm both load BASE; either beats auto-step.
        if (base_wr[i] || vblank_rise)
          cur_q[i] <= base_nx[i];
        else if (hit_p0[i] && (step_q[i] != 8'h00))
          cur_q[i] <= step_wrap(cur_q[i], step_q[i]);
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (io.io_addr)
      5'd0:    rdata = mask_q;
      5'd1:    rdata = stat_q;
      5'd2:    rdata = vpos[7:0];
      5'd3:    rdata = 8'(vpos >> 8);
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (io.io_addr[4:2] == 3'(i + 2)) begin
        case (io.io_addr[1:0])
          2'd0:    rdata = base_q[i][7:0];
          2'd1:    rdata = 8'(base_q[i] >> 8);
          2'd2:    rdata = step_q[i];
          default: rdata = cur_q[i][7:0];
        endcase
      end
    end
  end

  assign io.io_rddata = rdata;

endmodule
